// File: rtl/stack_control_unit.sv
// Multi-cycle control FSM for the stack machine datapath.
// Moore decode from the registered state; PCWrite in EX_BZ and ALUop in EX_ALU also follow inputs.
module stack_control_unit (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic        isZero,
  output logic        PCWrite,
  output logic        PCSource,
  output logic        PCAdd,
  output logic        IRWrite,
  output logic        ValAWrite,
  output logic        ValBWrite,
  output logic        MemRead1,
  output logic        MemRead2,
  output logic        MemWrite1,
  output logic        MemWrite2,
  output logic        MSPWrite,
  output logic        MSPop,
  output logic        RSPWrite,
  output logic        RSPop,
  output logic        ResSource,
  output logic        ResWrite,
  output logic [1:0]  MemDst1,
  output logic [1:0]  MemDst2,
  output logic [2:0]  MemData,
  output logic [3:0]  ALUop,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    INIT = 4'd0,  FETCH = 4'd1,  DECODE = 4'd2, DISPATCH = 4'd3,
    EX_LB = 4'd4, WB_LB = 4'd5,  EX_RP = 4'd6,  WB_RP = 4'd7,
    EX_JP = 4'd8, WB_JP = 4'd9,  EX_LM = 4'd10, WB_LM = 4'd11,
    EX_BR = 4'd12, EX_BZ = 4'd13, EX_ALU = 4'd14, HALT = 4'd15
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_q <= INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:     state_d = FETCH;
      FETCH:    state_d = DECODE;
      DECODE:   state_d = DISPATCH;
      DISPATCH: begin
        unique case (IROut[15:12])
          4'd1:    state_d = EX_LB;
          4'd2:    state_d = EX_RP;
          4'd3:    state_d = EX_JP;
          4'd4:    state_d = EX_LM;
          4'd5:    state_d = EX_BR;
          4'd6:    state_d = EX_BZ;
          4'd7:    state_d = EX_ALU;
          4'd15:   state_d = HALT;
          default: state_d = FETCH;  // NOP and unused opcodes
        endcase
      end
      EX_LB:    state_d = WB_LB;
      EX_RP:    state_d = WB_RP;
      EX_JP:    state_d = WB_JP;
      EX_LM:    state_d = WB_LM;
      HALT:     state_d = HALT;
      default:  state_d = FETCH;     // WB_x, EX_BR, EX_BZ, EX_ALU
    endcase
  end

  always_comb begin
    PCWrite = 1'b0; PCSource = 1'b0; PCAdd = 1'b0; IRWrite = 1'b0;
    ValAWrite = 1'b0; ValBWrite = 1'b0; MemRead1 = 1'b0; MemRead2 = 1'b0;
    MemWrite1 = 1'b0; MemWrite2 = 1'b0; MSPWrite = 1'b0; MSPop = 1'b0;
    RSPWrite = 1'b0; RSPop = 1'b0; ResSource = 1'b0; ResWrite = 1'b0;
    MemDst1 = 2'b00; MemDst2 = 2'b00; MemData = 3'b000; ALUop = 4'b0000;
    unique case (state_q)
      FETCH: begin
        PCWrite = 1'b1; MemRead1 = 1'b1; MemRead2 = 1'b1;
        MSPWrite = 1'b1; MSPop = 1'b1;
      end
      DECODE: begin
        IRWrite = 1'b1; ValAWrite = 1'b1;
      end
      EX_LB: begin
        MemRead1 = 1'b1; MemDst1 = 2'b01; MSPWrite = 1'b1;
      end
      WB_LB: ValBWrite = 1'b1;
      EX_RP: begin
        MemRead2 = 1'b1; MemDst2 = 2'b01; RSPWrite = 1'b1; RSPop = 1'b1;
      end
      WB_RP: ValAWrite = 1'b1;
      EX_JP: begin
        PCWrite = 1'b1; PCSource = 1'b1; MemRead2 = 1'b1;
        MSPWrite = 1'b1; MSPop = 1'b1;
      end
      WB_JP: ValAWrite = 1'b1;
      EX_LM: begin
        MemRead1 = 1'b1; MemRead2 = 1'b1; MemDst1 = 2'b10; MSPWrite = 1'b1;
      end
      WB_LM: begin
        ValAWrite = 1'b1; ValBWrite = 1'b1;
      end
      EX_BR: begin
        PCWrite = 1'b1; PCAdd = 1'b1;
      end
      EX_BZ: begin
        PCWrite = isZero; PCAdd = 1'b1;
      end
      EX_ALU: begin
        ALUop = IROut[3:0]; ResWrite = 1'b1;
      end
      default: ;  // INIT, DISPATCH, HALT drive nothing
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_stack_control_unit.sv
// Directed bench for stack_control_unit: walks each instruction class, async reset and HALT.
module tb_stack_control_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [15:0] IROut;
  logic        isZero;
  logic PCWrite, PCSource, PCAdd, IRWrite, ValAWrite, ValBWrite, MemRead1, MemRead2;
  logic MemWrite1, MemWrite2, MSPWrite, MSPop, RSPWrite, RSPop, ResSource, ResWrite;
  logic [1:0] MemDst1, MemDst2;
  logic [2:0] MemData;
  logic [3:0] ALUop, State;

  int checks = 0;
  int failures = 0;

  stack_control_unit dut (
    .CLK(CLK), .Reset(Reset), .IROut(IROut), .isZero(isZero),
    .PCWrite(PCWrite), .PCSource(PCSource), .PCAdd(PCAdd), .IRWrite(IRWrite),
    .ValAWrite(ValAWrite), .ValBWrite(ValBWrite), .MemRead1(MemRead1), .MemRead2(MemRead2),
    .MemWrite1(MemWrite1), .MemWrite2(MemWrite2), .MSPWrite(MSPWrite), .MSPop(MSPop),
    .RSPWrite(RSPWrite), .RSPop(RSPop), .ResSource(ResSource), .ResWrite(ResWrite),
    .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData), .ALUop(ALUop), .State(State)
  );

  always #5 CLK = ~CLK;

  // Every control output packed for all-zero checks (27 bits).
  logic [26:0] outs;
  assign outs = {PCWrite, PCSource, PCAdd, IRWrite, ValAWrite, ValBWrite, MemRead1, MemRead2,
                 MemWrite1, MemWrite2, MSPWrite, MSPop, RSPWrite, RSPop, ResSource, ResWrite,
                 MemDst1, MemDst2, MemData, ALUop};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset = 1'b1; IROut = 16'h0000; isZero = 1'b0;
    #12;
    check("rst_state", 32'(State), 32'd0);
    check("rst_outs", 32'(outs), 32'd0);
    Reset = 1'b0;

    // NOP: 0,1,2,3,1
    step(); check("nop_fetch", 32'(State), 32'd1);
    check("fetch_pcw", 32'(PCWrite), 32'd1);
    check("fetch_mspop", 32'(MSPop), 32'd1);
    check("fetch_memdst1", 32'(MemDst1), 32'd0);
    check("fetch_rd12", 32'({MemRead1, MemRead2, MSPWrite, PCAdd, PCSource}), 32'b11100);
    step(); check("nop_decode", 32'(State), 32'd2);
    check("decode_ctl", 32'({IRWrite, ValAWrite, PCWrite}), 32'b110);
    step(); check("nop_dispatch", 32'(State), 32'd3);
    check("dispatch_outs", 32'(outs), 32'd0);
    step(); check("nop_back", 32'(State), 32'd1);

    // JPOP
    IROut = 16'h3000;
    step(); step(); check("jp_dispatch", 32'(State), 32'd3);
    step(); check("jp_ex", 32'(State), 32'd8);
    check("jp_ctl", 32'({PCSource, PCWrite, MSPop, MSPWrite, MemRead2, MemDst2, RSPop}), 32'b11111000);
    step(); check("jp_wb", 32'(State), 32'd9);
    check("jp_wb_vala", 32'(ValAWrite), 32'd1);
    step(); check("jp_fetch", 32'(State), 32'd1);

    // BZ not taken, then taken
    IROut = 16'h6000; isZero = 1'b0;
    step(); step(); step(); check("bz0_state", 32'(State), 32'd13);
    check("bz0_pcw", 32'(PCWrite), 32'd0);
    check("bz0_pcadd", 32'(PCAdd), 32'd1);
    step(); check("bz0_fetch", 32'(State), 32'd1);
    isZero = 1'b1;
    step(); step(); step(); check("bz1_state", 32'(State), 32'd13);
    check("bz1_pc", 32'({PCWrite, PCAdd, PCSource}), 32'b110);
    isZero = 1'b0; #1;
    check("bz_comb_pcw", 32'(PCWrite), 32'd0);
    step(); check("bz1_fetch", 32'(State), 32'd1);

    // BR
    IROut = 16'h5000;
    step(); step(); step(); check("br_state", 32'(State), 32'd12);
    check("br_pc", 32'({PCWrite, PCAdd, PCSource}), 32'b110);
    step(); check("br_fetch", 32'(State), 32'd1);

    // ALU
    IROut = 16'h7005;
    step(); step(); step(); check("alu_state", 32'(State), 32'd14);
    check("alu_op", 32'(ALUop), 32'h5);
    check("alu_res", 32'({ResWrite, ResSource}), 32'b10);
    IROut = 16'h700A; #1;
    check("alu_op_comb", 32'(ALUop), 32'hA);
    step(); check("alu_fetch", 32'(State), 32'd1);
    check("fetch_aluop", 32'(ALUop), 32'd0);

    // LB
    IROut = 16'h1000;
    step(); step(); step(); check("lb_ex", 32'(State), 32'd4);
    check("lb_ctl", 32'({MemRead1, MemDst1, MSPWrite, MSPop}), 32'b10110);
    step(); check("lb_wb", 32'(State), 32'd5);
    check("lb_wb_valb", 32'({ValBWrite, ValAWrite}), 32'b10);
    step(); check("lb_fetch", 32'(State), 32'd1);

    // RP
    IROut = 16'h2000;
    step(); step(); step(); check("rp_ex", 32'(State), 32'd6);
    check("rp_ctl", 32'({MemRead2, MemDst2, RSPWrite, RSPop, MSPop, MSPWrite}), 32'b1011100);
    step(); check("rp_wb", 32'(State), 32'd7);
    check("rp_wb_vala", 32'(ValAWrite), 32'd1);
    step(); check("rp_fetch", 32'(State), 32'd1);

    // Illegal opcode behaves as NOP
    IROut = 16'h9000;
    step(); step(); step(); check("ill_fetch", 32'(State), 32'd1);

    // LM, then async reset in EX_LM
    IROut = 16'h4000;
    step(); step(); step(); check("lm_ex", 32'(State), 32'd10);
    check("lm_ctl", 32'({MemRead1, MemRead2, MemDst1, MemDst2, MSPWrite, MSPop}), 32'b11100010);
    #2 Reset = 1'b1;
    #1;
    check("lm_rst_state", 32'(State), 32'd0);
    check("lm_rst_mr1", 32'(MemRead1), 32'd0);
    check("lm_rst_outs", 32'(outs), 32'd0);
    #2 Reset = 1'b0;
    step(); check("lm_rst_fetch", 32'(State), 32'd1);

    // Full LM path
    step(); step(); step(); check("lm2_ex", 32'(State), 32'd10);
    step(); check("lm_wb", 32'(State), 32'd11);
    check("lm_wb_ctl", 32'({ValAWrite, ValBWrite}), 32'b11);
    step(); check("lm_fetch", 32'(State), 32'd1);

    // HALT holds for 10 cycles
    IROut = 16'hF000;
    step(); step(); step(); check("halt_enter", 32'(State), 32'd15);
    for (int i = 0; i < 10; i++) begin
      IROut = 16'h7005;
      step();
      check("halt_state", 32'(State), 32'd15);
      check("halt_outs", 32'(outs), 32'd0);
    end
    #2 Reset = 1'b1;
    #1;
    check("halt_rst_state", 32'(State), 32'd0);
    #2 Reset = 1'b0;
    step(); check("halt_rst_fetch", 32'(State), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
